// File: rtl/onehot_sweep_decoder.sv
// onehot_sweep_decoder
//
// Registered N-to-2^N one-hot decoder. It accepts requests over a valid/ready
// handshake. DIRECT requests latch a select and hold the decoded line. SWEEP
// requests walk the active line through all 2^N positions, up or down from a
// start index, wrapping around, and then return to idle.
//
// Parameters:
//   N       - select width; output width is 2^N (N >= 1)
//   REVERSE - 0: idx i drives y[i]; 1: idx i drives y[2^N-1-i]
//
// Ports:
//   clk          - rising-edge clock
//   rst_n        - asynchronous active-low reset
//   en_i         - global enable; 0 freezes state and forces y/done/ready low
//   in_valid_i   - request valid
//   in_ready_o   - block can accept a request (enabled and not sweeping)
//   sel_i        - start/target index, sampled on accept
//   mode_i       - 0 = DIRECT, 1 = SWEEP, sampled on accept
//   dir_i        - sweep direction, 0 = up, 1 = down, sampled on accept
//   y_o          - one-hot decoded lines, or all-zero
//   idx_o        - current registered index (always the natural index)
//   busy_o       - high while in the sweep state
//   done_o       - high in the cycle the last sweep position is driven
module onehot_sweep_decoder #(
    parameter int unsigned N       = 3,
    parameter bit          REVERSE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [N-1:0]        sel_i,
    input  logic                mode_i,
    input  logic                dir_i,
    output logic [(2**N)-1:0]   y_o,
    output logic [N-1:0]        idx_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned W        = 2 ** N;
    localparam logic [N:0]  LastStep = (N + 1)'(W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StSweep
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] idx_q, idx_d;
    logic [N:0]   step_q, step_d;
    logic         dir_q, dir_d;

    logic         accept;
    logic         last_step;
    logic [N-1:0] pos;

    assign in_ready_o = en_i && (state_q != StSweep);
    assign accept     = in_valid_i && in_ready_o;
    assign last_step  = (step_q == LastStep);

    // Next-state logic; en_i low leaves every register unchanged.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        step_d  = step_q;
        dir_d   = dir_q;
        unique case (state_q)
            StIdle, StHold: begin
                if (accept) begin
                    idx_d   = sel_i;
                    step_d  = '0;
                    dir_d   = dir_i;
                    state_d = mode_i ? StSweep : StHold;
                end
            end
            StSweep: begin
                if (en_i) begin
                    idx_d  = dir_q ? (idx_q - N'(1)) : (idx_q + N'(1));
                    step_d = step_q + (N + 1)'(1);
                    if (last_step) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            step_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
        end
    end

    // For an N-bit index, 2^N-1-i is simply the bitwise complement of i.
    assign pos = REVERSE ? ~idx_q : idx_q;

    // Decode only from registered state so no select/mode/dir path reaches y.
    always_comb begin
        y_o = '0;
        if (en_i && (state_q != StIdle)) begin
            y_o[pos] = 1'b1;
        end
    end

    assign idx_o  = idx_q;
    assign busy_o = (state_q == StSweep);
    assign done_o = (state_q == StSweep) && last_step && en_i;

endmodule
